// File: rtl/rsa_modexp_core_if.sv
// Byte-wide host register port of the RSA modular-exponentiation engine.
// The host drives the master side and the engine implements the slave side.
interface rsa_modexp_core_if #(
  parameter int ADDR_W = 5
);
  logic              we;
  logic              oe;
  logic              start;
  logic [1:0]        reg_sel;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_i;
  logic [7:0]        data_o;
  logic              ready;
  logic              err;

  modport master (
    output we, oe, start, reg_sel, addr, data_i,
    input  data_o, ready, err
  );

  modport slave (
    input  we, oe, start, reg_sel, addr, data_i,
    output data_o, ready, err
  );
endinterface

// File: rtl/rsa_modexp_core.sv
// RSA modular exponentiation M^E mod N using two concurrent bit-serial modular multipliers.
// Optional early termination on an exhausted exponent is enabled by the macro RSA_EARLY_EXIT_EN.
module rsa_modexp_core #(
  parameter int KEY_BITS = 256,
  parameter int ADDR_W   = 5
) (
  input logic               clk,
  input logic               reset,
  rsa_modexp_core_if.slave  host_if
);
  localparam int NB = KEY_BITS / 8;
  localparam int CW = $clog2(KEY_BITS + 1);

  typedef enum logic [1:0] {IDLE, PREP, MUL, UPD} state_t;

  state_t              state_q, state_d;
  logic [KEY_BITS-1:0] n_q, n_d, e_q, e_d, m_q, m_d, r_q, r_d;
  logic [KEY_BITS-1:0] res_q, res_d, base_q, base_d, exp_q, exp_d, mul_q, mul_d;
  logic [KEY_BITS-1:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic [CW-1:0]       cnt_q, cnt_d, mcnt_q, mcnt_d;
  logic                err_q, err_d;
  logic [KEY_BITS-1:0] new_res, rd_word;
  logic                done;

  // One step of the MSB-first double-and-add; acc and a are both below nn.
  function automatic logic [KEY_BITS-1:0] mstep(input logic [KEY_BITS-1:0] acc,
                                                input logic b,
                                                input logic [KEY_BITS-1:0] a,
                                                input logic [KEY_BITS-1:0] nn);
    logic [KEY_BITS:0] t, nx;
    nx = {1'b0, nn};
    t  = {acc, 1'b0};
    if (t >= nx) t = t - nx;
    if (b) t = t + {1'b0, a};
    if (t >= nx) t = t - nx;
    return t[KEY_BITS-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      r_q     <= '0;
      res_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      mul_q   <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      cnt_q   <= '0;
      mcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      e_q     <= e_d;
      m_q     <= m_d;
      r_q     <= r_d;
      res_q   <= res_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mul_q   <= mul_d;
      acc1_q  <= acc1_d;
      acc2_q  <= acc2_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    e_d     = e_q;
    m_d     = m_q;
    r_d     = r_q;
    res_d   = res_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mul_d   = mul_q;
    acc1_d  = acc1_q;
    acc2_d  = acc2_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    err_d   = err_q;
    new_res = exp_q[0] ? acc1_q : res_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (host_if.we) begin
          for (int b = 0; b < NB; b++) begin
            if (host_if.addr == ADDR_W'(b)) begin
              case (host_if.reg_sel)
                2'd0:    n_d[b*8 +: 8] = host_if.data_i;
                2'd1:    e_d[b*8 +: 8] = host_if.data_i;
                2'd2:    m_d[b*8 +: 8] = host_if.data_i;
                default: ;
              endcase
            end
          end
        end
        if (host_if.start) state_d = PREP;
      end
      PREP: begin
        if (n_q <= KEY_BITS'(1) || m_q >= n_q) begin
          r_d     = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          res_d   = KEY_BITS'(1);
          base_d  = m_q;
          mul_d   = m_q;
          exp_d   = e_q;
          err_d   = 1'b0;
          cnt_d   = '0;
          mcnt_d  = '0;
          acc1_d  = '0;
          acc2_d  = '0;
          state_d = MUL;
`ifdef RSA_EARLY_EXIT_EN
          if (e_q == '0) begin
            r_d     = KEY_BITS'(1);
            state_d = IDLE;
          end
`endif
        end
      end
      MUL: begin
        // Both products share the multiplier bits of base.
        acc1_d = mstep(acc1_q, mul_q[KEY_BITS-1], res_q, n_q);
        acc2_d = mstep(acc2_q, mul_q[KEY_BITS-1], base_q, n_q);
        mul_d  = mul_q << 1;
        mcnt_d = mcnt_q + CW'(1);
        if (mcnt_q == CW'(KEY_BITS - 1)) begin
          mcnt_d  = '0;
          state_d = UPD;
        end
      end
      UPD: begin
        res_d  = new_res;
        base_d = acc2_q;
        mul_d  = acc2_q;
        exp_d  = exp_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        acc1_d = '0;
        acc2_d = '0;
        done   = (cnt_q == CW'(KEY_BITS - 1));
`ifdef RSA_EARLY_EXIT_EN
        if ((exp_q >> 1) == '0) done = 1'b1;
`endif
        if (done) begin
          r_d     = new_res;
          state_d = IDLE;
        end else begin
          state_d = MUL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (host_if.reg_sel)
      2'd0:    rd_word = n_q;
      2'd1:    rd_word = e_q;
      2'd2:    rd_word = m_q;
      default: rd_word = r_q;
    endcase
    host_if.data_o = 8'h00;
    if (host_if.oe) begin
      for (int b = 0; b < NB; b++) begin
        if (host_if.addr == ADDR_W'(b)) host_if.data_o = rd_word[b*8 +: 8];
      end
    end
  end

  assign host_if.ready = (state_q == IDLE);
  assign host_if.err   = err_q;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed bench for rsa_modexp_core: a 16-bit and a 32-bit instance sharing the host write/read bus.
// Latency expectations follow RSA_EARLY_EXIT_EN when it is defined for the build.
module tb_rsa_modexp_core;
  logic       clk = 1'b0;
  logic       reset;
  logic       we, oe, start16, start32;
  logic [1:0] reg_sel;
  logic [4:0] addr;
  logic [7:0] data_i;
  bit         cur;
  int         n_checks = 0;
  int         n_errs   = 0;

  rsa_modexp_core_if #(.ADDR_W(5)) bus16 ();
  rsa_modexp_core_if #(.ADDR_W(5)) bus32 ();

  assign bus16.we = we;  assign bus16.oe = oe;  assign bus16.reg_sel = reg_sel;
  assign bus16.addr = addr;  assign bus16.data_i = data_i;  assign bus16.start = start16;
  assign bus32.we = we;  assign bus32.oe = oe;  assign bus32.reg_sel = reg_sel;
  assign bus32.addr = addr;  assign bus32.data_i = data_i;  assign bus32.start = start32;

  rsa_modexp_core #(.KEY_BITS(16), .ADDR_W(5)) dut16 (.clk(clk), .reset(reset), .host_if(bus16));
  rsa_modexp_core #(.KEY_BITS(32), .ADDR_W(5)) dut32 (.clk(clk), .reset(reset), .host_if(bus32));

  always #5 clk = ~clk;

  logic       ready_c, err_c;
  logic [7:0] dout_c;
  assign ready_c = cur ? bus32.ready  : bus16.ready;
  assign err_c   = cur ? bus32.err    : bus16.err;
  assign dout_c  = cur ? bus32.data_o : bus16.data_o;

`ifdef RSA_EARLY_EXIT_EN
  localparam int LAT_ENC = 86, LAT_DEC = 205, LAT_W32 = 562;
`else
  localparam int LAT_ENC = 273, LAT_DEC = 273, LAT_W32 = 1057;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_modexp(input longint unsigned m, input longint unsigned e,
                                                 input longint unsigned n);
    longint unsigned r, b, x;
    r = 1; b = m % n; x = e;
    while (x != 0) begin
      if (x[0]) r = (r * b) % n;
      b = (b * b) % n;
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic wr_word(input logic [1:0] rs, input logic [63:0] v, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      we = 1'b1; reg_sel = rs; addr = 5'(i); data_i = v[i*8 +: 8];
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_word(input logic [1:0] rs, input int nbytes, output logic [63:0] v);
    v = '0;
    oe = 1'b1; reg_sel = rs;
    for (int i = 0; i < nbytes; i++) begin
      addr = 5'(i);
      #1;
      v[i*8 +: 8] = dout_c;
    end
    oe = 1'b0;
  endtask

  task automatic set_ops(input logic [63:0] n, input logic [63:0] e, input logic [63:0] m, input int nb);
    wr_word(2'd0, n, nb);
    wr_word(2'd1, e, nb);
    wr_word(2'd2, m, nb);
  endtask

  // Returns the index of the edge at which ready comes back, counting the start edge as 0.
  task automatic run(input int disturb_at, output int lat);
    @(negedge clk);
    if (cur) start32 = 1'b1; else start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; start32 = 1'b0;
    lat = -1;
    for (int e = 1; e <= 2000; e++) begin
      @(negedge clk);
      if (ready_c) begin
        lat = e;
        break;
      end
      if (e == disturb_at) begin
        we = 1'b1; reg_sel = 2'd0; addr = 5'd0; data_i = 8'd5;
        if (cur) start32 = 1'b1; else start16 = 1'b1;
      end else if (e == disturb_at + 1) begin
        we = 1'b0; start16 = 1'b0; start32 = 1'b0;
      end
    end
    if (lat < 0) check("run_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [63:0] v, acc;
    int          lat;
    bit          stayed;
    reset = 1'b1; we = 1'b0; oe = 1'b0; start16 = 1'b0; start32 = 1'b0;
    reg_sel = 2'd0; addr = '0; data_i = '0; cur = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_ready", 64'(ready_c), 64'd1);
    check("rst_err",   64'(err_c),   64'd0);
    rd_word(2'd3, 2, v);
    check("rst_r", v, 64'd0);

    set_ops(64'd3233, 64'd17, 64'd65, 2);
    run(0, lat);
    check("enc_lat", 64'(lat), 64'(LAT_ENC));
    rd_word(2'd3, 2, v);
    check("enc_r", v, 64'd2790);
    check("enc_err", 64'(err_c), 64'd0);

    set_ops(64'd3233, 64'd2753, 64'd2790, 2);
    run(0, lat);
    check("dec_lat", 64'(lat), 64'(LAT_DEC));
    rd_word(2'd3, 2, v);
    check("dec_r", v, 64'd65);

    wr_word(2'd2, 64'd3233, 2);
    run(0, lat);
    check("inv_lat", 64'(lat), 64'd1);
    check("inv_err", 64'(err_c), 64'd1);
    rd_word(2'd3, 2, v);
    check("inv_r", v, 64'd0);

    set_ops(64'd3233, 64'd17, 64'd65, 2);
    run(0, lat);
    check("reval_err", 64'(err_c), 64'd0);
    rd_word(2'd3, 2, v);
    check("reval_r", v, 64'd2790);

    run(20, lat);
    check("busy_lat", 64'(lat), 64'(LAT_ENC));
    rd_word(2'd3, 2, v);
    check("busy_r", v, 64'd2790);
    rd_word(2'd0, 2, v);
    check("busy_n", v, 64'd3233);
    stayed = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!ready_c) stayed = 1'b0;
    end
    check("busy_no_rerun", 64'(stayed), 64'd1);

    set_ops(64'd1, 64'd17, 64'd0, 2);
    run(0, lat);
    check("n1_lat", 64'(lat), 64'd1);
    check("n1_err", 64'(err_c), 64'd1);
    #2 reset = 1'b1;
    #1 check("rst_err_async", 64'(err_c), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    set_ops(64'd3233, 64'd17, 64'd65, 2);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (50) @(negedge clk);
    check("mid_busy", 64'(ready_c), 64'd0);
    #2 reset = 1'b1;
    #1 check("mid_ready", 64'(ready_c), 64'd1);
    check("mid_err", 64'(err_c), 64'd0);
    acc = '0;
    for (int r = 0; r < 4; r++) begin
      rd_word(2'(r), 2, v);
      acc = acc | v;
    end
    check("mid_regs_zero", acc, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    cur = 1'b1;
    set_ops(64'd4294967291, 64'd65537, 64'd2, 4);
    for (int a = 4; a < 32; a++) begin
      @(negedge clk);
      we = 1'b1; reg_sel = 2'd0; addr = 5'(a); data_i = 8'hAA;
    end
    @(negedge clk);
    we = 1'b0;
    acc = '0;
    oe = 1'b1; reg_sel = 2'd0;
    for (int a = 4; a < 32; a++) begin
      addr = 5'(a);
      #1;
      acc = acc | 64'(dout_c);
    end
    oe = 1'b0;
    check("w32_oor_read", acc, 64'd0);
    @(negedge clk);
    rd_word(2'd0, 4, v);
    check("w32_n", v, 64'd4294967291);
    run(0, lat);
    check("w32_lat", 64'(lat), 64'(LAT_W32));
    rd_word(2'd3, 4, v);
    check("w32_r", v, ref_modexp(64'd2, 64'd65537, 64'd4294967291));
    check("w32_err", 64'(err_c), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
